darken_stream: RTL and testbench

DARKEN_STREAM -- requirements
Module: darken_stream

---
 rtl/image_pkg.sv | 24 ++
 rtl/darken_stream_if.sv | 31 +++
 rtl/sat_sub8.sv | 14 +
 rtl/darken_stream.sv | 147 ++++++++++++++
 tb/tb_darken_stream.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/image_pkg.sv
// rtl/image_pkg.sv - pixel field positions, alpha constant, FSM state type and clamp helper
package image_pkg;

  localparam int R_MSB = 31;
  localparam int R_LSB = 24;
  localparam int G_MSB = 23;
  localparam int G_LSB = 16;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  localparam logic [7:0] ALPHA_OPAQUE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // A set bit 8 is the borrow of an unsigned 8-bit subtraction; floor the result at zero.
  function automatic logic [7:0] clamp9(input logic [8:0] d);
    return d[8] ? 8'h00 : d[7:0];
  endfunction

endpackage

// File: rtl/darken_stream_if.sv
// rtl/darken_stream_if.sv - upstream and downstream pixel handshake bundle
interface darken_stream_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  // Pixel source / sink side: feeds in_*, consumes out_*
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  // Darkening engine side
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/sat_sub8.sv
// rtl/sat_sub8.sv - 8-bit subtract with floor at zero, also exposing the raw 9-bit difference
module sat_sub8
  import image_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [8:0] diff,
  output logic [7:0] y
);

  assign diff = {1'b0, a} - {1'b0, b};
  assign y    = clamp9(diff);

endmodule

// File: rtl/darken_stream.sv
// rtl/darken_stream.sv - frame-based pixel darkener with two-stage elastic pipeline
module darken_stream
  import image_pkg::*;
#(
  parameter int FRAME_PIXELS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       beta,
  darken_stream_if.slave   px,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = $clog2(FRAME_PIXELS + 1);
  // Count value just before the final pixel of the frame is accepted
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_PIXELS - 1);

  state_t          state;
  logic [CW-1:0]   count;
  logic [7:0]      beta_q;

  logic            s1_valid;
  logic [8:0]      s1_r;
  logic [8:0]      s1_g;
  logic [8:0]      s1_b;
  logic            s2_valid;
  logic [31:0]     s2_data;

  logic            adv1;
  logic            adv2;
  logic            in_fire;
  logic            drained;

  logic [8:0]      diff_r;
  logic [8:0]      diff_g;
  logic [8:0]      diff_b;
  logic [23:0]     unused_sat_y;
  logic [7:0]      unused_pad;

  // The middle byte of the input pixel carries nothing we use
  assign unused_pad = px.in_data[15:8];

  sat_sub8 u_sub_r (
    .a    (px.in_data[R_MSB:R_LSB]),
    .b    (beta_q),
    .diff (diff_r),
    .y    (unused_sat_y[23:16])
  );

  sat_sub8 u_sub_g (
    .a    (px.in_data[G_MSB:G_LSB]),
    .b    (beta_q),
    .diff (diff_g),
    .y    (unused_sat_y[15:8])
  );

  sat_sub8 u_sub_b (
    .a    (px.in_data[B_MSB:B_LSB]),
    .b    (beta_q),
    .diff (diff_b),
    .y    (unused_sat_y[7:0])
  );

  // S2 moves when it is empty or its pixel leaves; S1 moves when it is empty or S2 moves
  assign adv2         = !s2_valid || px.out_ready;
  assign adv1         = !s1_valid || adv2;
  assign px.in_ready  = (state == ST_RUN) && adv1;
  assign in_fire      = px.in_valid && px.in_ready;
  // Pipeline is empty now or becomes empty on this edge via the final output transfer
  assign drained      = !s1_valid && (!s2_valid || px.out_ready);

  assign px.out_valid = s2_valid;
  assign px.out_data  = s2_data;
  assign busy         = (state != ST_IDLE);

  // Frame control: accept a start, count accepted pixels, wait for the pipe to empty
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      count      <= '0;
      beta_q     <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A start coincident with the completion pulse belongs to the old frame
          if (start && !frame_done) begin
            beta_q <= beta;
            count  <= '0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (in_fire) begin
            count <= count + 1'b1;
            if (count == LAST_IDX) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drained) begin
            frame_done <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Stage 1: register the raw 9-bit per-channel differences
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_r     <= 9'h000;
      s1_g     <= 9'h000;
      s1_b     <= 9'h000;
    end else if (adv1) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_r <= diff_r;
        s1_g <= diff_g;
        s1_b <= diff_b;
      end
    end
  end

  // Stage 2: clamp on borrow and register the opaque output pixel; held while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= 32'h0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= {ALPHA_OPAQUE, clamp9(s1_r), clamp9(s1_g), clamp9(s1_b)};
      end
    end
  end

endmodule

// File: tb/tb_darken_stream.sv
// tb/tb_darken_stream.sv - scoreboard bench for darken_stream with directed frames
module tb_darken_stream;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] beta;
  logic       busy;
  logic       frame_done;

  darken_stream_if px();

  darken_stream #(.FRAME_PIXELS(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .beta       (beta),
    .px         (px),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          out_count  = 0;
  int          done_count = 0;
  int          out0;
  int          done0;
  bit          check_lat  = 1'b1;
  bit          rdy_toggle = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [31:0] exp_q[$];
  int          acc_q[$];

  logic [31:0] tbl_in  [4];
  logic [31:0] tbl_exp [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] sub_floor(input logic [7:0] x, input logic [7:0] b);
    if (x > b) return x - b;
    return 8'h00;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] d, input logic [7:0] b);
    return {8'hFF, sub_floor(d[31:24], b), sub_floor(d[23:16], b), sub_floor(d[7:0], b)};
  endfunction

  // Downstream ready: held high, or toggled every cycle
  initial begin
    px.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      px.out_ready = rdy_toggle ? ~px.out_ready : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each output transfer, checks stall stability
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", px.out_valid, 1'b1);
        check("stall_data_held", px.out_data, prev_data);
      end
      prev_stall = px.out_valid && !px.out_ready;
      prev_data  = px.out_data;
      if (px.out_valid && px.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %h, expected no output", px.out_data);
        end else begin
          logic [31:0] e;
          int a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("out_data", px.out_data, e);
          if (check_lat) check("latency", cyc - a, 2);
        end
        out_count++;
      end
      if (frame_done) begin
        done_count++;
        check("done_after_last_output", exp_q.size(), 0);
      end
    end
  end

  task automatic start_frame(input logic [7:0] b);
    @(posedge clk);
    #1;
    start = 1'b1;
    beta  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    out0  = out_count;
    done0 = done_count;
  endtask

  task automatic send_pixel(input logic [31:0] d, input logic [31:0] e);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    px.in_valid = 1'b1;
    px.in_data  = d;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (px.in_ready) begin
        exp_q.push_back(e);
        acc_q.push_back(cyc);
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_accept_timeout: got in_ready low for 200 cycles, expected acceptance");
    end
  endtask

  task automatic stop_input();
    @(posedge clk);
    #1;
    px.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (frame_done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_done_timeout: got no frame_done in 500 cycles, expected a pulse");
    end
  endtask

  // Waits for completion, tries a start in the frame_done cycle (must be ignored)
  task automatic finish_frame();
    wait_done();
    #1;
    check("frame_outputs", out_count - out0, 16);
    check("frame_done_pulses", done_count - done0, 1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("done_single_cycle", frame_done, 1'b0);
    check("start_in_done_ignored", busy, 1'b0);
  endtask

  initial begin
    tbl_in[0] = 32'h8040_3305;  tbl_exp[0] = 32'hFF70_3000;
    tbl_in[1] = 32'h1010_AA10;  tbl_exp[1] = 32'hFF00_0000;
    tbl_in[2] = 32'hFF11_000F;  tbl_exp[2] = 32'hFFEF_0100;
    tbl_in[3] = 32'h0020_FF30;  tbl_exp[3] = 32'hFF00_1020;

    rst         = 1'b1;
    start       = 1'b0;
    beta        = 8'h00;
    px.in_valid = 1'b0;
    px.in_data  = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", px.out_valid, 1'b0);
    check("reset_out_data", px.out_data, 32'h0);
    check("reset_in_ready", px.in_ready, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_frame_done", frame_done, 1'b0);
    #1;
    rst = 1'b0;

    // Frame A: beta 0x10, hand-computed table, includes the 2-cycle latency case
    start_frame(8'h10);
    @(negedge clk);
    check("busy_in_run", busy, 1'b1);
    for (int i = 0; i < 16; i++) send_pixel(tbl_in[i % 4], tbl_exp[i % 4]);
    stop_input();
    finish_frame();

    // Frame B: beta 0, random pixels pass through with alpha forced opaque
    start_frame(8'h00);
    for (int i = 0; i < 16; i++) begin
      logic [31:0] d;
      d = $urandom;
      send_pixel(d, {8'hFF, d[31:16], d[7:0]});
    end
    stop_input();
    finish_frame();

    // Frame C: downstream ready toggles every cycle
    check_lat  = 1'b0;
    rdy_toggle = 1'b1;
    start_frame(8'h20);
    for (int i = 0; i < 16; i++) begin
      logic [31:0] d;
      d = $urandom;
      send_pixel(d, model(d, 8'h20));
    end
    stop_input();
    finish_frame();
    rdy_toggle = 1'b0;
    repeat (2) @(posedge clk);
    check_lat = 1'b1;

    // Frame D: beta and start disturbed mid-frame must not matter
    start_frame(8'h08);
    for (int i = 0; i < 16; i++) begin
      logic [31:0] d;
      if (i == 5) begin
        beta  = 8'hFF;
        start = 1'b1;
      end
      if (i == 8) start = 1'b0;
      d = $urandom;
      send_pixel(d, model(d, 8'h08));
    end
    stop_input();
    finish_frame();

    // Frame E: reset after 5 accepted pixels, then a clean full frame
    start_frame(8'h40);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] d;
      d = $urandom;
      send_pixel(d, model(d, 8'h40));
    end
    @(posedge clk);
    #1;
    rst         = 1'b1;
    px.in_valid = 1'b0;
    exp_q.delete();
    acc_q.delete();
    done0 = done_count;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", px.out_valid, 1'b0);
    check("midrst_out_data", px.out_data, 32'h0);
    check("midrst_in_ready", px.in_ready, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_frame_done", frame_done, 1'b0);
    #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_no_done", done_count - done0, 0);
    start_frame(8'h40);
    for (int i = 0; i < 16; i++) begin
      logic [31:0] d;
      d = $urandom;
      send_pixel(d, model(d, 8'h40));
    end
    stop_input();
    finish_frame();

    // Frame F: in_valid stays high past the last pixel; nothing more is accepted
    start_frame(8'h01);
    for (int i = 0; i < 16; i++) begin
      logic [31:0] d;
      d = $urandom;
      send_pixel(d, model(d, 8'h01));
    end
    @(posedge clk);
    #1;
    px.in_data = 32'hDEAD_BEEF;
    begin
      bit got;
      got = 1'b0;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        check("drain_in_ready_low", px.in_ready, 1'b0);
        if (frame_done) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        n_checks++;
        n_fail++;
        $display("FAIL drain_timeout: got no frame_done in 200 cycles, expected a pulse");
      end
    end
    #1;
    px.in_valid = 1'b0;
    check("held_valid_outputs", out_count - out0, 16);
    check("held_valid_done", done_count - done0, 1);
    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
